// File: rtl/sipo_register_if.sv
// Bus bundle for sipo_register: serial-line inputs plus the valid/ready parallel output side.
// The slave modport is the receiver's view; master is the line driver / consumer view.
interface sipo_register_if #(
   parameter int WIDTH = 4
);
   logic             s_in;
   logic             s_en;
   logic             sof;
   logic [WIDTH-1:0] d_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             frame_err;
   logic             overrun;
   logic             par_err;

   modport slave (
      input  s_in, s_en, sof, out_ready,
      output d_out, out_valid, busy, frame_err, overrun, par_err
   );

   modport master (
      output s_in, s_en, sof, out_ready,
      input  d_out, out_valid, busy, frame_err, overrun, par_err
   );
endinterface

// File: rtl/sipo_register.sv
// Serial-in/parallel-out receiver: framed MSB-first bit stream into a single-entry valid/ready buffer.
// Optional trailing even-parity bit is checked when PARITY_CHECK_EN is defined.
module sipo_register #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   sipo_register_if.slave bus
);

   localparam int               CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] r_dout;
   logic             r_out_valid;
   logic             r_frame_err;
   logic             r_overrun;

   logic             w_first;
   logic             w_abort;
   logic             w_shift;
   logic             w_complete;
   logic             w_busy;
   logic             w_accept;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [WIDTH-1:0] w_word;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.s_en && bus.sof) w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (bus.s_en && !bus.sof && (r_cnt == LAST_DATA)) begin
`ifdef PARITY_CHECK_EN
               w_state_nxt = S_PAR;
`else
               w_state_nxt = S_IDLE;
`endif
            end
         end
`ifdef PARITY_CHECK_EN
         S_PAR: begin
            // a sof here restarts the frame just as it does in SHIFT
            if (bus.s_en) w_state_nxt = bus.sof ? S_SHIFT : S_IDLE;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_first    = 1'b0;
      w_abort    = 1'b0;
      w_shift    = 1'b0;
      w_complete = 1'b0;
      w_busy     = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            w_first = bus.s_en && bus.sof;
         end
         S_SHIFT: begin
            w_abort = bus.s_en && bus.sof;
            w_shift = bus.s_en && !bus.sof;
`ifndef PARITY_CHECK_EN
            w_complete = bus.s_en && !bus.sof && (r_cnt == LAST_DATA);
`endif
         end
`ifdef PARITY_CHECK_EN
         S_PAR: begin
            w_abort    = bus.s_en && bus.sof;
            w_complete = bus.s_en && !bus.sof;
         end
`endif
         default: ;
      endcase
   end

   // truncating cast drops the oldest bit; it has already left the frame window
   assign w_shreg_nxt = WIDTH'({r_shreg, bus.s_in});

`ifdef PARITY_CHECK_EN
   logic r_par_err;
   logic w_word_par;
   assign w_word     = r_shreg;
   assign w_word_par = (^r_shreg) ^ bus.s_in;
`else
   assign w_word     = w_shreg_nxt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_abort;
         if (w_first || w_abort) begin
            r_shreg <= {{(WIDTH-1){1'b0}}, bus.s_in};
            r_cnt   <= CNT_W'(1);
         end else begin
            if (w_shift)         r_shreg <= w_shreg_nxt;
            if (w_complete)      r_cnt   <= '0;
            else if (w_shift)    r_cnt   <= r_cnt + CNT_W'(1);
         end
      end
   end

   // single-entry buffer: a slot is free when empty or being drained this cycle
   assign w_accept = !r_out_valid || bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dout      <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else if (w_complete) begin
         if (w_accept) begin
            r_dout      <= w_word;
            r_out_valid <= 1'b1;
         end else begin
            r_overrun   <= 1'b1;
         end
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef PARITY_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      r_par_err <= 1'b0;
      else if (w_complete && w_accept) r_par_err <= w_word_par;
   end
   assign bus.par_err = r_par_err;
`else
   assign bus.par_err = 1'b0;
`endif

   assign bus.d_out     = r_dout;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = w_busy;
   assign bus.frame_err = r_frame_err;
   assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_register.sv
// Scoreboard bench for sipo_register (WIDTH=4): directed frames push expected words,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_sipo_register;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   logic [W:0] exp_q[$];

   sipo_register_if #(.WIDTH(W)) bus();

   sipo_register #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // monitor: a handshake seen at negedge is consumed at the following posedge
   initial begin
      logic [W:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%0h, required no word", {bus.par_err, bus.d_out});
            end else begin
               e = exp_q.pop_front();
               check("sb_word", 32'({bus.par_err, bus.d_out}), 32'(e));
            end
         end
      end
   end

   task automatic step(input logic b, input logic e, input logic f);
      bus.s_in = b;
      bus.s_en = e;
      bus.sof  = f;
      @(posedge clk);
      #1;
      bus.s_en = 1'b0;
      bus.sof  = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input int gap, input bit ready_last,
                            input bit flip, input bit deliver);
      logic [W:0] bits;
      int nb;
`ifdef PARITY_CHECK_EN
      nb   = W + 1;
      bits = {w, (^w) ^ flip};
      if (deliver) exp_q.push_back({flip, w});
`else
      nb   = W;
      bits = {flip, w};
      if (deliver) exp_q.push_back({1'b0, w});
`endif
      for (int i = nb - 1; i >= 0; i--) begin
         if (i == 0 && ready_last) bus.out_ready = 1'b1;
         step(bits[i], 1'b1, (i == nb - 1));
         if (i != 0) begin
            for (int g = 0; g < gap; g++) begin
               check("gap_busy", bus.busy, 1);
               check("gap_frame_err", bus.frame_err, 0);
               step(1'b1, 1'b0, 1'b1);
            end
         end
      end
      check("busy_after_frame", bus.busy, 0);
   endtask

   initial begin
      n_cmp         = 0;
      n_fail        = 0;
      rst_n         = 1'b1;
      bus.s_in      = 1'b0;
      bus.s_en      = 1'b0;
      bus.sof       = 1'b0;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_d_out", bus.d_out, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_frame_err", bus.frame_err, 0);
      check("rst_overrun", bus.overrun, 0);
      check("rst_par_err", bus.par_err, 0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic frame, latency and drain
      send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1);
      check("t1_valid_latency", bus.out_valid, 1);
      check("t1_d_out", bus.d_out, 4'b1011);
      step(1'b0, 1'b0, 1'b0);
      check("t1_valid_drop", bus.out_valid, 0);

      // gapped strobes
      send_word(4'b0110, 3, 1'b0, 1'b0, 1'b1);
      check("t2_d_out", bus.d_out, 4'b0110);
      step(1'b0, 1'b0, 1'b0);

      // abort mid-frame
      exp_q.push_back({1'b0, 4'b0001});
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check("t3_frame_err_pulse", bus.frame_err, 1);
      check("t3_busy", bus.busy, 1);
      check("t3_no_aborted_word", bus.out_valid, 0);
      step(1'b0, 1'b1, 1'b0);
      check("t3_frame_err_clear", bus.frame_err, 0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
      step(1'b1, 1'b1, 1'b0);
`endif
      check("t3_d_out", bus.d_out, 4'b0001);
      check("t3_busy_done", bus.busy, 0);
      step(1'b0, 1'b0, 1'b0);

      // sof on the completing bit aborts instead of completing
      exp_q.push_back({1'b0, 4'b0110});
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
      step(1'b1, 1'b1, 1'b0);
`endif
      step(1'b0, 1'b1, 1'b1);
      check("t3b_frame_err", bus.frame_err, 1);
      check("t3b_not_completed", bus.out_valid, 0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
      step(1'b0, 1'b1, 1'b0);
`endif
      check("t3b_d_out", bus.d_out, 4'b0110);
      step(1'b0, 1'b0, 1'b0);

      // overrun
      bus.out_ready = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      send_word(4'hA, 0, 1'b0, 1'b0, 1'b1);
      check("t4_a_valid", bus.out_valid, 1);
      check("t4_a_overrun", bus.overrun, 0);
      step(1'b0, 1'b0, 1'b0);
      send_word(4'h5, 0, 1'b0, 1'b0, 1'b0);
      check("t4_overrun_set", bus.overrun, 1);
      check("t4_d_out_held", bus.d_out, 4'hA);
      check("t4_valid_held", bus.out_valid, 1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("t4_overrun_sticky", bus.overrun, 1);
      send_word(4'h3, 0, 1'b1, 1'b0, 1'b1);
      check("t4_d_out_new", bus.d_out, 4'h3);
      check("t4_valid_kept", bus.out_valid, 1);
      check("t4_overrun_kept", bus.overrun, 1);
      step(1'b0, 1'b0, 1'b0);
      check("t4_valid_drained", bus.out_valid, 0);

      // asynchronous reset mid-frame
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check("t5_busy_before", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_d_out", bus.d_out, 0);
      check("t5_out_valid", bus.out_valid, 0);
      check("t5_busy", bus.busy, 0);
      check("t5_overrun", bus.overrun, 0);
      check("t5_frame_err", bus.frame_err, 0);
      check("t5_par_err", bus.par_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check("t5_no_sof_ignored", bus.busy, 0);
      end
      check("t5_no_word", bus.out_valid, 0);

`ifdef PARITY_CHECK_EN
      send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1);
      check("t6_par_ok", bus.par_err, 0);
      send_word(4'b1011, 0, 1'b0, 1'b1, 1'b1);
      check("t6_par_bad", bus.par_err, 1);
      check("t6_bad_delivered", bus.out_valid, 1);
`endif

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      check("sb_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
